bias_add_14: RTL

Stream consumer for layer 14's bias stream: the receive-side counterpart of the layer-14 bias streamer. It pops `kern_s_k_14` bias coefficients from an ap_fifo read port and caches them locally. It then adds the matching per-channel bias to each convolution result on a second ap_fifo input, saturates the sum, and pushes it to an ap_fifo output. It sits between the layer-14 conv accumulator stream and the next layer's input FIFO.

---
 rtl/bias_add_14_pkg.sv | 16 +
 rtl/bias_regfile.sv | 28 ++
 rtl/bias_add_14.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bias_add_14_pkg.sv
// Shared constants for the layer-14 bias-add stage: frame geometry defaults,
// coefficient width default and FSM state encodings.
package bias_add_14_pkg;

    // Layer-14 geometry defaults (output channels, output pixels per frame).
    localparam int unsigned KERN_S_K_14 = 16;
    localparam int unsigned OUT_S_14    = 169;

    // Default coefficient / data width.
    localparam int unsigned COEFF_WIDTH = 16;

    // FSM state encodings.
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/bias_regfile.sv
// Per-channel bias cache: one synchronous write port, one combinational read port.
module bias_regfile
    import bias_add_14_pkg::*;
#(
    parameter int unsigned N_CH    = KERN_S_K_14,
    parameter int unsigned COEFF_W = COEFF_WIDTH,
    parameter int unsigned ADDR_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [COEFF_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [COEFF_W-1:0] o_rdata
);

    logic [COEFF_W-1:0] r_mem [N_CH];

    // Cache write; contents are fully rewritten every frame, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bias_add_14.sv
// Layer-14 bias stage: caches one frame's worth of biases from the bias FIFO,
// then adds the per-channel bias to each conv result with saturation.
module bias_add_14
    import bias_add_14_pkg::*;
#(
    parameter int unsigned N_CH    = KERN_S_K_14,
    parameter int unsigned N_PIX   = OUT_S_14,
    parameter int unsigned COEFF_W = COEFF_WIDTH,
    parameter int unsigned DATA_W  = COEFF_WIDTH
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [COEFF_W-1:0] bias_V_dout,
    input  logic               bias_V_empty_n,
    output logic               bias_V_read,
    input  logic [DATA_W-1:0]  input_V_dout,
    input  logic               input_V_empty_n,
    output logic               input_V_read,
    output logic [DATA_W-1:0]  output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write
);

    localparam int unsigned SUM_W = ((DATA_W > COEFF_W) ? DATA_W : COEFF_W) + 1;
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

    // Clamp bounds expressed in the widened sum domain.
    localparam logic [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic [0:0]        r_state;
    logic [CH_W-1:0]   r_ch_cnt;
    logic [PIX_W-1:0]  r_pix_cnt;
    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_reg;

    logic               w_bias_pop;
    logic               w_in_pop;
    logic               w_out_wr;
    logic [COEFF_W-1:0] w_bias;
    logic [SUM_W-1:0]   w_data_ext;
    logic [SUM_W-1:0]   w_bias_ext;
    logic [SUM_W-1:0]   w_sum;
    logic [DATA_W-1:0]  w_sat;

    // Strobes are gated by reset so nothing is popped or pushed while it is held.
    assign w_bias_pop = ap_rst_n & (r_state == ST_LOAD) & bias_V_empty_n;
    assign w_in_pop   = ap_rst_n & (r_state == ST_RUN) & input_V_empty_n
                        & (~r_out_vld | output_V_full_n);
    assign w_out_wr   = ap_rst_n & r_out_vld & output_V_full_n;

    assign bias_V_read    = w_bias_pop;
    assign input_V_read   = w_in_pop;
    assign output_V_write = w_out_wr;
    assign output_V_din   = r_out_reg;

    // Load and lookup share the channel counter: it walks the cache in both states.
    bias_regfile #(
        .N_CH    (N_CH),
        .COEFF_W (COEFF_W),
        .ADDR_W  (CH_W)
    ) u_bias_regfile (
        .i_clk   (ap_clk),
        .i_we    (w_bias_pop),
        .i_waddr (r_ch_cnt),
        .i_wdata (bias_V_dout),
        .i_raddr (r_ch_cnt),
        .o_rdata (w_bias)
    );

    assign w_data_ext = {{(SUM_W - DATA_W){input_V_dout[DATA_W-1]}}, input_V_dout};
    assign w_bias_ext = {{(SUM_W - COEFF_W){w_bias[COEFF_W-1]}}, w_bias};
    assign w_sum      = w_data_ext + w_bias_ext;

    // Saturate the widened sum back into the signed data range.
    always_comb begin
        w_sat = w_sum[DATA_W-1:0];
        if ($signed(w_sum) > $signed(SAT_MAX)) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if ($signed(w_sum) < $signed(SAT_MIN)) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    // FSM and channel/pixel counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= ST_LOAD;
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_bias_pop) begin
                        if (r_ch_cnt == CH_LAST) begin
                            r_ch_cnt  <= '0;
                            r_pix_cnt <= '0;
                            r_state   <= ST_RUN;
                        end else begin
                            r_ch_cnt <= r_ch_cnt + CH_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (w_in_pop) begin
                        if (r_ch_cnt == CH_LAST) begin
                            r_ch_cnt <= '0;
                            if (r_pix_cnt == PIX_LAST) begin
                                r_pix_cnt <= '0;
                                r_state   <= ST_LOAD;
                            end else begin
                                r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                            end
                        end else begin
                            r_ch_cnt <= r_ch_cnt + CH_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // Output register: a new pop replaces the value, a write alone retires it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_vld <= 1'b0;
            r_out_reg <= '0;
        end else if (w_in_pop) begin
            r_out_vld <= 1'b1;
            r_out_reg <= w_sat;
        end else if (w_out_wr) begin
            r_out_vld <= 1'b0;
        end
    end

endmodule
